// File: rtl/t_ff_divider_ctrl_pkg.sv
// Shared encodings and defaults for the T flip-flop divider controller.
// The state enum reuses the numeric codes so that waveforms and other blocks agree on them.
package t_ff_ctrl_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic logic is_zero(input logic [CNT_W_DEF-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/t_ff_divider_ctrl_if.sv
// Control/status bundle between the controlling logic (master) and the divider (slave).
interface t_ff_divider_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] div_val;
    logic [CNT_W-1:0] num_toggles;
    logic             t_out;
    logic             q;
    logic             qbar;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, div_val, num_toggles,
        input  t_out, q, qbar, busy, done
    );

    modport slave (
        input  start, stop, div_val, num_toggles,
        output t_out, q, qbar, busy, done
    );
endinterface

// File: rtl/t_ff_divider_ctrl_stage.sv
// Rising-edge T flip-flop primitive with synchronous active-high reset.
module t_ff_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = t ? ~q_q : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
endmodule

// File: rtl/t_ff_divider_ctrl.sv
// Sequencer that strobes a T stage once every (div_val+1) cycles, for a
// programmed number of toggles or continuously until stopped.
module t_ff_divider_ctrl
    import t_ff_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    t_ff_divider_ctrl_if.slave  bus
);
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] div_cnt_q,  div_cnt_d;
    logic [CNT_W-1:0] tog_left_q, tog_left_d;
    logic [CNT_W-1:0] div_lat_q,  div_lat_d;
    logic             cont_q,     cont_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             t_out;

    // Gated by rst so no strobe escapes in the cycle a reset is being applied.
    assign t_out = (state_q == S_RUN) && (div_cnt_q == '0) && !bus.stop && !rst;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        tog_left_d = tog_left_q;
        div_lat_d  = div_lat_q;
        cont_d     = cont_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    div_lat_d  = bus.div_val;
                    tog_left_d = bus.num_toggles;
                    cont_d     = (bus.num_toggles == '0);
                    div_cnt_d  = bus.div_val;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    div_cnt_d = div_lat_q;
                    // Continuous runs leave tog_left untouched so it never wraps.
                    if (!cont_q) begin
                        tog_left_d = tog_left_q - 1'b1;
                        if (tog_left_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            tog_left_q <= '0;
            div_lat_q  <= '0;
            cont_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tog_left_q <= tog_left_d;
            div_lat_q  <= div_lat_d;
            cont_q     <= cont_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    t_ff_stage u_stage (
        .clk  (clk),
        .rst  (rst),
        .t    (t_out),
        .q    (bus.q),
        .qbar (bus.qbar)
    );

    assign bus.t_out = t_out;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
